// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_32b slice.
package sync_fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    typedef logic [31:0] data_t;

    // Pointer width: storage index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one write port and one synchronous read port.
// The array and the read register are not reset; the top masks rdata after reset.
module fifo_mem_2p #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read port: holds when not enabled; a same-edge write to raddr returns old data
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_32b.sv
// Synchronous FIFO feeding a 32-bit pipeline register's D input.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_32b
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int PTR_W  = ptr_w(DEPTH),
    localparam int ADDR_W = PTR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic              ovf,
    output logic              udf,
`endif
    output logic [ADDR_W:0]   count
);

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_rd_vld;   // set by the first accepted read after reset
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_mem_q;

    // Flags derive only from registered pointers
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_wr_ptr - r_rd_ptr;

    // Pointer advance and read-data-valid tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_vld <= 1'b1;
            end
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_mem_q)
    );

    // Reset forces rd_data to zero at once, so stale storage never shows
    assign rd_data = r_rd_vld ? w_mem_q : '0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en & ~w_wr_acc) r_ovf <= 1'b1;
            if (rd_en & w_empty)   r_udf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

endmodule

// File: tb/tb_sync_fifo_32b.sv
// Directed bench for sync_fifo_32b with a queue-based reference model.
// Also covers the SYNC_FIFO_ERR_FLAGS_EN build when that macro is defined.
module tb_sync_fifo_32b;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        full;
    logic        empty;
    logic [31:0] rd_data;
    logic [3:0]  count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        ovf;
    logic        udf;
`endif

    int nvec = 0;
    int nerr = 0;

    sync_fifo_32b dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .ovf     (ovf),
        .udf     (udf),
`endif
        .count   (count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the last word read out
    logic [31:0] q[$];
    logic [31:0] m_rd  = '0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            automatic bit ra = rd_en && (q.size() != 0);
            automatic bit wa = wr_en && ((q.size() < DEPTH) || ra);
            if (rd_en && q.size() == 0) m_udf = 1'b1;
            if (wr_en && !wa)           m_ovf = 1'b1;
            if (ra) m_rd = q.pop_front();
            if (wa) q.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
        chk("count", {28'd0, count}, q.size());
        chk("rd_data", rd_data, m_rd);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        chk("udf", {31'd0, udf}, {31'd0, m_udf});
`endif
    end

    // One clock: drive inputs, take the edge, return just after it
    task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset, then idle
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        cyc(0, 0, 0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_rd",    rd_data,        32'h0);

        // Fill, then one dropped write
        for (int i = 1; i <= 8; i++) cyc(1, 32'hDEAD_0000 + i, 0);
        chk("fill_full",  {31'd0, full},  32'd1);
        chk("fill_count", {28'd0, count}, 32'd8);
        cyc(1, 32'hBAD0_BAD0, 0);
        chk("drop_count", {28'd0, count}, 32'd8);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_set", {31'd0, ovf}, 32'd1);
`endif

        // Drain in order, then one read while empty
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1);
            chk("drain_rd", rd_data, 32'hDEAD_0000 + i);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        cyc(0, 0, 1);
        chk("udf_hold", rd_data, 32'hDEAD_0008);
        chk("model_hold", m_rd, 32'hDEAD_0008);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("udf_set", {31'd0, udf}, 32'd1);
`endif

        // Full with simultaneous read/write, across the pointer wrap
        for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, i, 1);
            chk("rw_full_rd", rd_data, 32'hA0 + i - 1);
            chk("rw_full_cnt", {28'd0, count}, 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1);
            chk("wrap_rd", rd_data, (i < 4) ? 32'hA4 + i : i - 3);
        end

        // Empty with simultaneous read/write: no bypass
        cyc(1, 32'hCAFE_F00D, 1);
        chk("rw_empty_cnt", {28'd0, count}, 32'd1);
        chk("rw_empty_rd",  rd_data,        32'h4);
        cyc(0, 0, 1);
        chk("cafe_rd", rd_data, 32'hCAFE_F00D);
        chk("model_cafe", m_rd, 32'hCAFE_F00D);

        // Reset in the middle of a cycle
        for (int i = 0; i < 3; i++) cyc(1, 32'h5500 + i, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cnt",   {28'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_rd",    rd_data,        32'h0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        chk("mid_rst_udf", {31'd0, udf}, 32'd0);
`endif
        @(negedge clk);
        #2 reset = 1'b0;
        cyc(0, 0, 1);
        chk("post_rst_rd",    rd_data,        32'h0);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);
        cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Safety net: never hang
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
